// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and default width for the RV32M muldiv sequencer.
package muldiv_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between EX stage (master) and the muldiv sequencer (slave).
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, op, rs1, rs2, flush, input busy, done, result);
    modport slave(input start, op, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring shift-subtract divide on a shared accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] m_i,
    input  logic [2*XLEN:0] acc_i,
    output logic [2*XLEN:0] acc_o
);
    logic [XLEN:0] sum, top, diff;
    logic          ge;
    always_comb begin
        sum   = acc_i[2*XLEN:XLEN] + (acc_i[0] ? {1'b0, m_i} : '0);
        top   = acc_i[2*XLEN-1:XLEN-1];
        ge    = top >= {1'b0, m_i};
        diff  = top - {1'b0, m_i};
        acc_o = is_div_i ? (ge ? {diff, acc_i[XLEN-2:0], 1'b1} : {acc_i[2*XLEN-1:0], 1'b0})
                         : {1'b0, sum, acc_i[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer with start/busy/done handshake.
// Define MULDIV_EARLY_OUT_EN to let MUL* ops leave CALC once the remaining multiplier bits are zero.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, m_q, res_q;
    logic [2*XLEN:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q, done_q;
    logic              is_div, is_rem, mul_hi, sgn_a, sgn_b, neg_a, neg_b, dz, ovf, early, skip;
    logic [XLEN-1:0]   a_mag, b_mag, q_fix, r_fix, res_fix, spec_res;
    logic [2*XLEN-1:0] prod, prod_fix;
`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0]  cnt_n;
    logic [XLEN-1:0]   mask;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i(is_div),
        .m_i     (m_q),
        .acc_i   (acc_q),
        .acc_o   (acc_d)
    );

    always_comb begin
        is_div   = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_rem   = op_q inside {OP_REM, OP_REMU};
        mul_hi   = op_q inside {OP_MULH, OP_MULHSU, OP_MULHU};
        sgn_a    = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sgn_b    = op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg_a    = sgn_a & a_q[XLEN-1];
        neg_b    = sgn_b & b_q[XLEN-1];
        a_mag    = neg_a ? -a_q : a_q;
        b_mag    = neg_b ? -b_q : b_q;
        dz       = is_div && b_q == '0;
        ovf      = is_div && sgn_a && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1;
        spec_res = dz ? (is_rem ? a_q : '1) : (is_rem ? '0 : a_q);
`ifdef MULDIV_EARLY_OUT_EN
        // Bits below cnt_n in the low half are the multiplier bits still to be consumed.
        cnt_n    = cnt_q - 1'b1;
        mask     = ~({XLEN{1'b1}} << cnt_n);
        early    = !is_div && (acc_d[XLEN-1:0] & mask) == '0;
        skip     = !is_div && b_mag == '0;
        prod     = acc_q[2*XLEN-1:0] >> cnt_q;
`else
        early    = 1'b0;
        skip     = 1'b0;
        prod     = acc_q[2*XLEN-1:0];
`endif
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        q_fix    = (neg_a ^ neg_b) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        r_fix    = neg_a ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        res_fix  = is_div ? (is_rem ? r_fix : q_fix)
                          : (mul_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= bus.start ? PREP : IDLE;
                    busy_q  <= bus.start;
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.rs1;
                        b_q  <= bus.rs2;
                    end
                end
                PREP: begin
                    m_q   <= is_div ? b_mag : a_mag;
                    acc_q <= {{(XLEN+1){1'b0}}, is_div ? a_mag : b_mag};
                    cnt_q <= CNT_W'(XLEN);
                    if (dz || ovf) begin
                        res_q   <= spec_res;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= skip ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1) || early) state_q <= FIX;
                end
                FIX: begin
                    res_q   <= res_fix;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
endmodule
